// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
//   Bundle of every bus signal around the RAM arbiter: the instruction-fetch
//   side, the data-memory side and the single RAM port.
//
//   modport slave  : the arbiter's view (requests and RAM status in; grants,
//                    RAM controls and load data out).
//   modport master : the surroundings' view (core + RAM model), the mirror.
//
//   Signals
//     iREN, iaddr            instruction read request / address
//     iload, iwait           instruction data / hold request
//     dREN, dWEN             data read / write request
//     daddr, dstore          data address / write value
//     dload, dwait           data read value / hold request
//     ramREN, ramWEN         RAM read / write enable
//     ramaddr, ramstore      RAM address / write data
//     ramload, ramstate      RAM read data / status (FREE, BUSY, ACCESS, ERROR)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares the single RAM port between the instruction-fetch and data-memory
//   paths of the pipelined core. A three-state FSM (IDLE, IGRANT, DGRANT)
//   grants one side at a time, data side first. Address, store data and
//   enables pass straight through to the RAM; load data goes back to both
//   sides and each side gets its own wait signal. Every output is
//   combinational from the state register and the requester inputs.
//
//   Optional feature: define MEM_ARB_STARVE_GUARD_EN to add a 3-bit saturating
//   streak counter that forces an instruction grant after STARVE_LIMIT
//   consecutive data completions while iREN is pending. Without the macro,
//   data requests have strict priority.
//
//   Parameters
//     STARVE_LIMIT  data completions (iREN pending) before a forced
//                   instruction grant, legal range 1..7
//   Ports
//     CLK   clock, rising edge
//     nRST  reset, asynchronous, active-low
//     bus   mem_arbiter_if.slave: requester sides and RAM port
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // Out-of-range limits are rejected at elaboration.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_limit_check
    $error("mem_arbiter: STARVE_LIMIT must be within 1..7");
  end

  state_t state_q;
  state_t state_d;

  logic dreq;
  logic i_done;
  logic d_done;
  logic ram_ends;
  logic force_igrant;

  assign dreq     = bus.dREN | bus.dWEN;
  assign i_done   = (state_q == IGRANT) && (bus.ramstate == RAM_ACCESS);
  assign d_done   = (state_q == DGRANT) && (bus.ramstate == RAM_ACCESS);
  // ACCESS completes the grant; ERROR drops it so the still-waiting requester
  // is re-arbitrated from IDLE and the access is retried.
  assign ram_ends = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [2:0] STREAK_LIMIT = 3'(STARVE_LIMIT);

  // Counts consecutive data completions that happened while the instruction
  // side was left waiting.
  logic [2:0] streak_q;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      streak_q <= '0;
    end else if (i_done) begin
      streak_q <= '0;
    end else if (d_done) begin
      if (!bus.iREN)             streak_q <= '0;
      else if (streak_q != 3'd7) streak_q <= streak_q + 3'd1;
    end
  end

  assign force_igrant = (streak_q >= STREAK_LIMIT) && bus.iREN;
`else
  assign force_igrant = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state_q)
      IDLE: begin
        if (force_igrant)  state_d = IGRANT;
        else if (dreq)     state_d = DGRANT;
        else if (bus.iREN) state_d = IGRANT;
      end

      IGRANT: begin
        // Enable follows the request so a withdrawn fetch stops at once.
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        if (!bus.iREN || ram_ends) state_d = IDLE;
      end

      DGRANT: begin
        // A write wins when both enables are raised.
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (!dreq || ram_ends) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.iwait = bus.iREN & ~i_done;
  assign bus.dwait = dreq & ~d_done;
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A table of per-cycle vectors walks the
//   instruction read, simultaneous request, ERROR retry, write-wins and
//   withdrawal cases; hand-written sequences cover starvation and a reset
//   during a data write grant. Expected values are written by hand against
//   the arbiter's behaviour. Inputs change on the falling edge and outputs
//   are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int unsigned LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  // Grant codes observed on the RAM port.
  localparam int G_NONE  = 0;
  localparam int G_IREAD = 1;
  localparam int G_DREAD = 2;
  localparam int G_DWRT  = 3;

  logic clk;
  logic nrst;
  int   checks;
  int   failures;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] rload;
    logic [1:0]  rstate;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_iwait;
    logic        e_dwait;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input string n, input logic ir, input logic dr, input logic dw,
    input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
    input logic [31:0] rl, input logic [1:0] rs,
    input logic ren, input logic wen, input logic [31:0] addr,
    input logic [31:0] store, input logic iw, input logic dwt);
    vec_t v;
    v.name = n;   v.iren = ir;   v.dren = dr;     v.dwen = dw;
    v.iaddr = ia; v.daddr = da;  v.dstore = ds;   v.rload = rl;
    v.rstate = rs;
    v.e_ren = ren; v.e_wen = wen; v.e_addr = addr; v.e_store = store;
    v.e_iwait = iw; v.e_dwait = dwt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic dw,
                       input logic [31:0] ia, input logic [31:0] da,
                       input logic [31:0] ds, input logic [31:0] rl,
                       input logic [1:0] rs);
    bus.iREN = ir;  bus.dREN = dr;    bus.dWEN = dw;
    bus.iaddr = ia; bus.daddr = da;   bus.dstore = ds;
    bus.ramload = rl; bus.ramstate = rs;
  endtask

  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    drive(v.iren, v.dren, v.dwen, v.iaddr, v.daddr, v.dstore, v.rload, v.rstate);
    #1;
    check({v.name, ".ramREN"},   bus.ramREN,   v.e_ren);
    check({v.name, ".ramWEN"},   bus.ramWEN,   v.e_wen);
    check({v.name, ".ramaddr"},  bus.ramaddr,  v.e_addr);
    check({v.name, ".ramstore"}, bus.ramstore, v.e_store);
    check({v.name, ".iwait"},    bus.iwait,    v.e_iwait);
    check({v.name, ".dwait"},    bus.dwait,    v.e_dwait);
    check({v.name, ".iload"},    bus.iload,    v.rload);
    check({v.name, ".dload"},    bus.dload,    v.rload);
  endtask

  function automatic int grant_code();
    if (bus.ramREN && !bus.ramWEN && bus.ramaddr == 32'h400) return G_IREAD;
    if (bus.ramWEN)                                          return G_DWRT;
    if (bus.ramREN)                                          return G_DREAD;
    return G_NONE;
  endfunction

  // Held requests from both sides with RAM always in ACCESS, starting in IDLE
  // with a cleared streak: grants land on odd cycles; with the guard every
  // (LIMIT+1)-th grant goes to the instruction side.
  function automatic int exp_code(input int k, input int dcode);
    int g;
    if (k % 2 == 0) return G_NONE;
    g = (k - 1) / 2;
    if (GUARD && (g % (LIMIT + 1)) == LIMIT) return G_IREAD;
    return dcode;
  endfunction

  // Caller positions the bench on a falling edge for k = 0.
  task automatic run_pattern(input string name, input int n, input int dcode);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check($sformatf("%s[%0d]", name, k), 32'(grant_code()), 32'(exp_code(k, dcode)));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nrst     = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h40, 32'h100, 32'h1, 32'h0, ACCESS);

    // Reset state: requests present but no enables, both sides waiting.
    #2;
    check("rst.ramREN",   bus.ramREN,   1'b0);
    check("rst.ramWEN",   bus.ramWEN,   1'b0);
    check("rst.ramaddr",  bus.ramaddr,  32'h0);
    check("rst.ramstore", bus.ramstore, 32'h0);
    check("rst.iwait",    bus.iwait,    1'b1);
    check("rst.dwait",    bus.dwait,    1'b1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    //                  name            iR dR dW iaddr   daddr   dstore        rload         rs      ren wen addr    store         iw dw
    vecs.push_back(mk("ird_idle",      1, 0, 0, 32'h40, 32'h0,   32'h0,        32'h0,        FREE,   0, 0, 32'h0,   32'h0,        1, 0));
    vecs.push_back(mk("ird_busy",      1, 0, 0, 32'h40, 32'h0,   32'h0,        32'h0,        BUSY,   1, 0, 32'h40,  32'h0,        1, 0));
    vecs.push_back(mk("ird_access",    1, 0, 0, 32'h40, 32'h0,   32'h0,        32'h8C010004, ACCESS, 1, 0, 32'h40,  32'h0,        0, 0));
    vecs.push_back(mk("ird_back_idle", 1, 0, 0, 32'h44, 32'h0,   32'h0,        32'h0,        ACCESS, 0, 0, 32'h0,   32'h0,        1, 0));
    vecs.push_back(mk("ird2_access",   1, 0, 0, 32'h44, 32'h0,   32'h0,        32'h0000ABCD, ACCESS, 1, 0, 32'h44,  32'h0,        0, 0));
    vecs.push_back(mk("quiet1",        0, 0, 0, 32'h0,  32'h0,   32'h0,        32'h0,        FREE,   0, 0, 32'h0,   32'h0,        0, 0));
    vecs.push_back(mk("sim_idle",      1, 0, 1, 32'h80, 32'h100, 32'hDEADBEEF, 32'h0,        FREE,   0, 0, 32'h0,   32'h0,        1, 1));
    vecs.push_back(mk("sim_dgrant",    1, 0, 1, 32'h80, 32'h100, 32'hDEADBEEF, 32'h0,        BUSY,   0, 1, 32'h100, 32'hDEADBEEF, 1, 1));
    vecs.push_back(mk("sim_daccess",   1, 0, 1, 32'h80, 32'h100, 32'hDEADBEEF, 32'h0,        ACCESS, 0, 1, 32'h100, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk("sim_gap",       1, 0, 0, 32'h80, 32'h100, 32'hDEADBEEF, 32'h0,        ACCESS, 0, 0, 32'h0,   32'h0,        1, 0));
    vecs.push_back(mk("sim_igrant",    1, 0, 0, 32'h80, 32'h0,   32'h0,        32'h11112222, ACCESS, 1, 0, 32'h80,  32'h0,        0, 0));
    vecs.push_back(mk("quiet2",        0, 0, 0, 32'h0,  32'h0,   32'h0,        32'h0,        FREE,   0, 0, 32'h0,   32'h0,        0, 0));
    vecs.push_back(mk("err_idle",      0, 1, 0, 32'h0,  32'h200, 32'h5555,     32'h0,        FREE,   0, 0, 32'h0,   32'h0,        0, 1));
    vecs.push_back(mk("err_grant",     0, 1, 0, 32'h0,  32'h200, 32'h5555,     32'h0,        ERROR,  1, 0, 32'h200, 32'h5555,     0, 1));
    vecs.push_back(mk("err_reidle",    0, 1, 0, 32'h0,  32'h200, 32'h5555,     32'h0,        ACCESS, 0, 0, 32'h0,   32'h0,        0, 1));
    vecs.push_back(mk("err_retry",     0, 1, 0, 32'h0,  32'h200, 32'h5555,     32'hCAFE0001, ACCESS, 1, 0, 32'h200, 32'h5555,     0, 0));
    vecs.push_back(mk("quiet3",        0, 0, 0, 32'h0,  32'h0,   32'h0,        32'h0,        FREE,   0, 0, 32'h0,   32'h0,        0, 0));
    vecs.push_back(mk("both_idle",     0, 1, 1, 32'h0,  32'h300, 32'h12345678, 32'h0,        FREE,   0, 0, 32'h0,   32'h0,        0, 1));
    vecs.push_back(mk("both_write",    0, 1, 1, 32'h0,  32'h300, 32'h12345678, 32'h0,        ACCESS, 0, 1, 32'h300, 32'h12345678, 0, 0));
    vecs.push_back(mk("quiet4",        0, 0, 0, 32'h0,  32'h0,   32'h0,        32'h0,        FREE,   0, 0, 32'h0,   32'h0,        0, 0));
    vecs.push_back(mk("wd_idle",       1, 0, 0, 32'h60, 32'h0,   32'h0,        32'h0,        FREE,   0, 0, 32'h0,   32'h0,        1, 0));
    vecs.push_back(mk("wd_free_hold",  1, 0, 0, 32'h60, 32'h0,   32'h0,        32'h0,        FREE,   1, 0, 32'h60,  32'h0,        1, 0));
    vecs.push_back(mk("wd_drop",       0, 0, 0, 32'h60, 32'h0,   32'h0,        32'h0,        BUSY,   0, 0, 32'h60,  32'h0,        0, 0));
    vecs.push_back(mk("wd_idle_after", 1, 0, 0, 32'h64, 32'h0,   32'h0,        32'h0,        BUSY,   0, 0, 32'h0,   32'h0,        1, 0));
    vecs.push_back(mk("wd_regrant",    1, 0, 0, 32'h64, 32'h0,   32'h0,        32'h0BADF00D, ACCESS, 1, 0, 32'h64,  32'h0,        0, 0));
    vecs.push_back(mk("quiet5",        0, 0, 0, 32'h0,  32'h0,   32'h0,        32'h0,        FREE,   0, 0, 32'h0,   32'h0,        0, 0));

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    // Starvation: both sides request reads continuously, RAM always ready.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h400, 32'h500, 32'h0, 32'h0, ACCESS);
    run_pattern("starve", 20, G_DREAD);

    // Build a streak of three write completions, then reset inside the
    // fourth write grant while the RAM reports BUSY.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h400, 32'h700, 32'hA5A5A5A5, 32'h0, ACCESS);
    repeat (5) @(negedge clk);
    @(negedge clk);
    bus.ramstate = BUSY;
    @(negedge clk);
    #1;
    check("pre_rst.ramWEN",  bus.ramWEN,  1'b1);
    check("pre_rst.ramaddr", bus.ramaddr, 32'h700);
    #1;
    nrst = 1'b0;
    #1;
    check("mid_rst.ramWEN",   bus.ramWEN,   1'b0);
    check("mid_rst.ramREN",   bus.ramREN,   1'b0);
    check("mid_rst.ramaddr",  bus.ramaddr,  32'h0);
    check("mid_rst.ramstore", bus.ramstore, 32'h0);
    check("mid_rst.dwait",    bus.dwait,    1'b1);
    check("mid_rst.iwait",    bus.iwait,    1'b1);
    @(negedge clk);
    nrst = 1'b1;
    bus.ramstate = ACCESS;
    // A cleared streak means four write grants before the instruction grant.
    run_pattern("post_rst", 12, G_DWRT);

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, FREE);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single RAM port between the instruction-fetch path and the data-memory path of the pipelined MIPS core. A three-state FSM grants the port to one requester at a time, data side first. It passes address, store data and enables through to RAM and returns load data and per-side wait signals. An optional anti-starvation counter forces an instruction grant after a run of data grants.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive completed data grants, with iREN pending, before the next grant is forced to the instruction side. Legal range 1–7.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction data, equals ramload
- iwait  out  1  instruction side must hold its request
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  data read value, equals ramload
- dwait  out  1  data side must hold its request
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

## Operation
- States are IDLE, IGRANT and DGRANT. Reset enters IDLE with the streak counter at 0.
- IDLE:
  - ram enables are 0; ramaddr and ramstore are 0.
  - If dREN|dWEN is asserted, go to DGRANT. The exception is a forced instruction grant (see Configuration).
  - Otherwise, if iREN is asserted, go to IGRANT. With no request, stay in IDLE.
- IGRANT:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - When ramstate==ACCESS, iwait=0 for that cycle, then go to IDLE.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN. ramREN=dREN&~dWEN, so a write wins if both are asserted.
  - When ramstate==ACCESS, dwait=0 for that cycle, then go to IDLE.
- Wait signals: iwait = iREN & ~(IGRANT & ACCESS). dwait = (dREN|dWEN) & ~(DGRANT & ACCESS). A side with no request sees wait=0.
- ERROR in a grant state: the requester keeps wait=1 and the FSM returns to IDLE. The request is re-arbitrated, so it is retried.
- Request withdrawn during its grant (enables drop before ACCESS): the FSM returns to IDLE next cycle. The RAM enables follow the requester inputs, so they drop immediately.
- ramstate FREE or BUSY in a grant state: hold the state and all outputs.
- iload and dload both carry ramload at all times. They are valid only on the owner's wait=0 cycle.

## Timing
- A request seen in IDLE at cycle N enters its grant state at N+1. The earliest completion is in cycle N+1 (ACCESS during the grant), so latency is at least 2 cycles.
- After every completion the FSM passes through IDLE for exactly one cycle. Back-to-back transactions are therefore spaced at least 2 cycles apart.
- A requester must hold its address, data and enable stable until its wait=0 cycle.
- All RAM outputs are combinational from state and requester inputs. No output is registered.
- Asserting nRST mid-transaction forces IDLE immediately: enables go to 0 asynchronously and the counter clears. The requester still sees wait=1 and is re-served after reset.

## Configuration
- Macro MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit saturating streak counter increments on each DGRANT completion while iREN is high.
  - It clears on any IGRANT completion, or on a DGRANT completion with iREN low.
  - In IDLE, when streak ≥ STARVE_LIMIT and iREN=1, the arbiter goes to IGRANT even if a data request is pending.
- Undefined: the counter is absent and data requests have strict priority. The instruction side can starve indefinitely.

## Test plan
- Instruction read only: iREN=1, iaddr=0x40. RAM returns ACCESS on its 2nd grant cycle with ramload=0x8C010004. Required: ramREN=1, ramaddr=0x40; iwait=0 exactly once, with iload=0x8C010004; FSM back in IDLE.
- Simultaneous requests: iREN=1 and dWEN=1 with daddr=0x100, dstore=0xDEADBEEF. Required: DGRANT first, with ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF. After dwait=0, one IDLE cycle, then IGRANT.
- ERROR retry: dREN=1, ramstate=ERROR on the first grant cycle, then ACCESS. Required: dwait stays 1 through the error, the FSM goes IDLE→DGRANT again, and dwait=0 on the later ACCESS.
- Starvation (guard on, STARVE_LIMIT=4): iREN and dREN held high, RAM always ACCESS. Required: 4 data completions, then an instruction grant, then data again. With the guard off, no instruction grant occurs in 20 cycles.
- Reset mid-grant: pull nRST low during DGRANT with ramWEN=1. Required: ramWEN=0 immediately, FSM in IDLE, counter 0; after release, the write is re-granted.
- Withdrawal: iREN drops during IGRANT with ramstate=BUSY. Required: ramREN=0 the same cycle, FSM in IDLE next cycle, iwait=0.
